// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the line-fetch FSM encoding.
// Used by the timing generator and by the frame-buffer line fetcher.
package vga_timing_pkg;

    localparam int unsigned HACTIVE   = 640;
    localparam int unsigned VACTIVE   = 480;
    localparam int unsigned VTOTAL    = 525;
    localparam int unsigned BURST_LEN = 32;

    localparam int unsigned BURSTS_PER_LINE = HACTIVE / BURST_LEN;
    localparam int unsigned BEAT_W          = $clog2(BURST_LEN);
    localparam int unsigned BURST_W         = $clog2(BURSTS_PER_LINE);
    localparam int unsigned PIX_W           = 10;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_DATA = 2'd2,
        FETCH_NEXT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/vga_line_fetch_ctrl.sv
// Fetches the next display line from the frame buffer in bursts and writes it
// into the ping-pong line-buffer bank that scan-out is not currently reading.
module vga_line_fetch_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned           ADDR_W     = 20,
    parameter logic [ADDR_W-1:0]     FRAME_BASE = '0
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic [10:0]       in_hcnt,
    input  logic [10:0]       in_vcnt,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    output logic              lb_wr_en,
    output logic [10:0]       lb_wr_addr,
    output logic [15:0]       lb_wr_data,
    output logic              out_busy,
    output logic              out_underrun,
    input  logic              clr_underrun
);

    fetch_state_e         state_q, state_d;
    logic [ADDR_W-1:0]    lineAddr_q, lineAddr_d;
    logic [ADDR_W-1:0]    memAddr_q;
    logic [BURST_W-1:0]   burstCnt_q;
    logic [BEAT_W-1:0]    beatCnt_q;
    logic [PIX_W-1:0]     pixCnt_q;
    logic                 bank_q;
    logic                 lbWrEn_q;
    logic [10:0]          lbWrAddr_q;
    logic [15:0]          lbWrData_q;
    logic                 underrun_q;

    logic trigLine0, trigOther, trigger, trigBank;
    logic lastBeat, lastBurst, beatAccept;

    // Trigger fires at the start of h-blank for the line preceding each active line.
    assign trigLine0  = (in_hcnt == 11'(HACTIVE)) && (in_vcnt == 11'(VTOTAL - 1));
    assign trigOther  = (in_hcnt == 11'(HACTIVE)) && (in_vcnt < 11'(VACTIVE - 1));
    assign trigger    = trigLine0 | trigOther;
    assign trigBank   = trigLine0 ? 1'b0 : ~in_vcnt[0];
    assign lineAddr_d = trigLine0 ? FRAME_BASE : lineAddr_q + ADDR_W'(HACTIVE);

    assign lastBeat   = (beatCnt_q == BEAT_W'(BURST_LEN - 1));
    assign lastBurst  = (burstCnt_q == BURST_W'(BURSTS_PER_LINE - 1));
    assign beatAccept = (state_q == FETCH_DATA) && mem_rvalid;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH_IDLE: if (trigger)                state_d = FETCH_REQ;
            FETCH_REQ:  if (mem_ack)                state_d = FETCH_DATA;
            FETCH_DATA: if (mem_rvalid && lastBeat) state_d = FETCH_NEXT;
            FETCH_NEXT: state_d = lastBurst ? FETCH_IDLE : FETCH_REQ;
            default:    state_d = FETCH_IDLE;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        out_busy = 1'b0;
        mem_req  = (state_q == FETCH_REQ);
        out_busy = (state_q != FETCH_IDLE);
    end

    // Line address advances on every trigger, even dropped ones, so one late
    // fetch never shifts the addresses of the lines after it.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            lineAddr_q <= '0;
            memAddr_q  <= '0;
            burstCnt_q <= '0;
            beatCnt_q  <= '0;
            pixCnt_q   <= '0;
            bank_q     <= 1'b0;
        end else begin
            if (trigger) begin
                lineAddr_q <= lineAddr_d;
            end
            unique case (state_q)
                FETCH_IDLE: begin
                    if (trigger) begin
                        memAddr_q  <= lineAddr_d;
                        burstCnt_q <= '0;
                        beatCnt_q  <= '0;
                        pixCnt_q   <= '0;
                        bank_q     <= trigBank;
                    end
                end
                FETCH_DATA: begin
                    if (mem_rvalid) begin
                        beatCnt_q <= lastBeat ? '0 : beatCnt_q + 1'b1;
                        pixCnt_q  <= pixCnt_q + 1'b1;
                    end
                end
                FETCH_NEXT: begin
                    if (!lastBurst) begin
                        burstCnt_q <= burstCnt_q + 1'b1;
                        memAddr_q  <= memAddr_q + ADDR_W'(BURST_LEN);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            lbWrEn_q   <= 1'b0;
            lbWrAddr_q <= '0;
            lbWrData_q <= '0;
        end else begin
            lbWrEn_q <= beatAccept;
            if (beatAccept) begin
                lbWrAddr_q <= {bank_q, pixCnt_q};
                lbWrData_q <= mem_rdata;
            end
        end
    end

    // A new underrun outranks a simultaneous clear.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_q <= 1'b0;
        end else if (trigger && (state_q != FETCH_IDLE)) begin
            underrun_q <= 1'b1;
        end else if (clr_underrun) begin
            underrun_q <= 1'b0;
        end
    end

    assign mem_addr     = memAddr_q;
    assign lb_wr_en     = lbWrEn_q;
    assign lb_wr_addr   = lbWrAddr_q;
    assign lb_wr_data   = lbWrData_q;
    assign out_underrun = underrun_q;

endmodule

// File: tb/tb_vga_line_fetch_ctrl.sv
// Directed bench for vga_line_fetch_ctrl: a behavioural arbiter answers each
// burst request and a monitor logs line-buffer writes for later comparison.
module tb_vga_line_fetch_ctrl;

    localparam int BURSTS = 20;
    localparam int BLEN   = 32;
    localparam int LINE   = 640;

    logic        pclk;
    logic        reset_n;
    logic [10:0] in_hcnt;
    logic [10:0] in_vcnt;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        lb_wr_en;
    logic [10:0] lb_wr_addr;
    logic [15:0] lb_wr_data;
    logic        out_busy;
    logic        out_underrun;
    logic        clr_underrun;

    int checks = 0;
    int errors = 0;

    logic        ackHold   = 1'b0;
    logic        spurious  = 1'b0;
    logic [19:0] burstBase = '0;

    logic [19:0] reqLog[$];
    logic [10:0] wrAddrLog[$];
    logic [15:0] wrDataLog[$];

    vga_line_fetch_ctrl dut (
        .pclk         (pclk),
        .reset_n      (reset_n),
        .in_hcnt      (in_hcnt),
        .in_vcnt      (in_vcnt),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .lb_wr_en     (lb_wr_en),
        .lb_wr_addr   (lb_wr_addr),
        .lb_wr_data   (lb_wr_data),
        .out_busy     (out_busy),
        .out_underrun (out_underrun),
        .clr_underrun (clr_underrun)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Pixel content is a function of its frame-buffer address, so every write
    // can be traced back to the word that should have produced it.
    function automatic logic [15:0] pixOf(input logic [19:0] addr);
        return addr[15:0] ^ 16'hA5A5;
    endfunction

    // Returns -1 when the logged requests are exactly base, base+32, ...; -2 on wrong count.
    function automatic int reqMismatch(input logic [19:0] base);
        if (reqLog.size() != BURSTS) return -2;
        for (int k = 0; k < BURSTS; k++)
            if (reqLog[k] !== base + 20'(BLEN * k)) return k;
        return -1;
    endfunction

    function automatic int writeMismatch(input logic [19:0] base, input logic bank);
        logic [10:0] a;
        if (wrAddrLog.size() != LINE) return -2;
        for (int i = 0; i < LINE; i++) begin
            a = {bank, 10'(i)};
            if (wrAddrLog[i] !== a || wrDataLog[i] !== pixOf(base + 20'(i))) return i;
        end
        return -1;
    endfunction

    // Arbiter model: acks two cycles after seeing a request (longer while
    // ackHold is set), then returns one burst of back-to-back words.
    initial begin : arbiter
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge pclk);
            if (reset_n && mem_req) begin
                burstBase = mem_addr;
                reqLog.push_back(mem_addr);
                mem_rvalid = 1'b0;
                repeat (2) @(negedge pclk);
                while (ackHold && reset_n) @(negedge pclk);
                if (reset_n) begin
                    mem_ack = 1'b1;
                    @(negedge pclk);
                    mem_ack = 1'b0;
                    for (int i = 0; i < BLEN; i++) begin
                        if (!reset_n) break;
                        mem_rdata  = pixOf(burstBase + 20'(i));
                        mem_rvalid = 1'b1;
                        @(negedge pclk);
                    end
                    mem_rvalid = 1'b0;
                end
            end else begin
                mem_rvalid = spurious;
                mem_rdata  = 16'hDEAD;
            end
        end
    end

    // Monitor for line-buffer writes.
    always @(negedge pclk) begin
        if (lb_wr_en === 1'b1) begin
            wrAddrLog.push_back(lb_wr_addr);
            wrDataLog.push_back(lb_wr_data);
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clearLogs();
        reqLog.delete();
        wrAddrLog.delete();
        wrDataLog.delete();
    endtask

    // One-cycle hcnt==640 pulse on line v, optionally with a simultaneous clear.
    task automatic pulseTrigger(input int v, input logic clr);
        @(negedge pclk);
        in_vcnt      = 11'(v);
        in_hcnt      = 11'd640;
        clr_underrun = clr;
        @(negedge pclk);
        in_hcnt      = 11'd100;
        clr_underrun = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (out_busy === 1'b1 && n < 3000) begin
            @(negedge pclk);
            n++;
        end
        checks++;
        if (out_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_idle: out_busy=%b after %0d cycles, required 0", name, out_busy, n);
        end
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        in_hcnt      = 11'd0;
        in_vcnt      = 11'd0;
        clr_underrun = 1'b0;
        repeat (3) @(negedge pclk);
        checks++;
        if (mem_req !== 1'b0 || out_busy !== 1'b0 || lb_wr_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: req=%b busy=%b wr_en=%b, required 0 0 0", mem_req, out_busy, lb_wr_en);
        end
        checks++;
        if (mem_addr !== 20'd0 || lb_wr_addr !== 11'd0 || lb_wr_data !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: addr=%h wr_addr=%h wr_data=%h, required 0 0 0", mem_addr, lb_wr_addr, lb_wr_data);
        end
        checks++;
        if (out_underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_underrun: got %b, required 0", out_underrun);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge pclk);
        checks++;
        if (mem_req !== 1'b0 || out_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: req=%b busy=%b, required 0 0", mem_req, out_busy);
        end
    endtask

    task automatic test_line0();
        int r;
        clearLogs();
        pulseTrigger(524, 1'b0);
        checks++;
        if (out_busy !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 20'd0) begin
            errors++;
            $display("[TB] FAIL line0_start: busy=%b req=%b addr=%0d, required 1 1 0", out_busy, mem_req, mem_addr);
        end
        waitIdle("line0");
        r = reqMismatch(20'd0);
        checks++;
        if (r != -1) begin
            errors++;
            $display("[TB] FAIL line0_reqs: %0d reqs, bad index %0d, required 20 at 0+32*k", reqLog.size(), r);
        end
        r = writeMismatch(20'd0, 1'b0);
        checks++;
        if (r != -1) begin
            errors++;
            $display("[TB] FAIL line0_writes: %0d writes, bad index %0d, required 640 to bank 0", wrAddrLog.size(), r);
        end
    endtask

    task automatic test_line1();
        int r;
        clearLogs();
        pulseTrigger(0, 1'b0);
        checks++;
        if (mem_addr !== 20'd640) begin
            errors++;
            $display("[TB] FAIL line1_first_addr: got %0d, required 640", mem_addr);
        end
        waitIdle("line1");
        r = reqMismatch(20'd640);
        checks++;
        if (r != -1) begin
            errors++;
            $display("[TB] FAIL line1_reqs: %0d reqs, bad index %0d, required 20 at 640+32*k", reqLog.size(), r);
        end
        r = writeMismatch(20'd640, 1'b1);
        checks++;
        if (r != -1) begin
            errors++;
            $display("[TB] FAIL line1_writes: %0d writes, bad index %0d, required 640 to bank 1", wrAddrLog.size(), r);
        end
        checks++;
        if (wrAddrLog.size() != LINE || wrAddrLog[0] !== 11'h400 || wrAddrLog[LINE-1] !== 11'h67F) begin
            errors++;
            $display("[TB] FAIL line1_bounds: %0d writes, required first 0x400 last 0x67F", wrAddrLog.size());
        end
    endtask

    task automatic test_ack_stall();
        int r;
        int bad = 0;
        clearLogs();
        ackHold = 1'b1;
        pulseTrigger(1, 1'b0);
        for (int c = 0; c < 50; c++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 20'd1280 || lb_wr_en !== 1'b0) begin
                errors++;
                bad++;
                $display("[TB] FAIL stall_hold cycle %0d: req=%b addr=%0d wr_en=%b, required 1 1280 0", c, mem_req, mem_addr, lb_wr_en);
            end
            @(negedge pclk);
        end
        ackHold = 1'b0;
        waitIdle("stall");
        r = reqMismatch(20'd1280);
        checks++;
        if (r != -1) begin
            errors++;
            $display("[TB] FAIL stall_reqs: %0d reqs, bad index %0d, required 20 at 1280+32*k", reqLog.size(), r);
        end
        r = writeMismatch(20'd1280, 1'b0);
        checks++;
        if (r != -1) begin
            errors++;
            $display("[TB] FAIL stall_writes: %0d writes, bad index %0d, required 640 to bank 0", wrAddrLog.size(), r);
        end
    endtask

    // Lines 3 and 4 back to back; bank alternates with the fetched line's parity.
    task automatic test_back_to_back();
        int r;
        logic [19:0] base;
        logic bank;
        for (int v = 2; v <= 3; v++) begin
            clearLogs();
            base = 20'((v + 1) * LINE);
            bank = (v % 2 == 0);
            pulseTrigger(v, 1'b0);
            waitIdle("b2b");
            r = reqMismatch(base);
            checks++;
            if (r != -1) begin
                errors++;
                $display("[TB] FAIL b2b_reqs v=%0d: %0d reqs, bad index %0d, required 20 at %0d+32*k", v, reqLog.size(), r, base);
            end
            r = writeMismatch(base, bank);
            checks++;
            if (r != -1) begin
                errors++;
                $display("[TB] FAIL b2b_writes v=%0d: %0d writes, bad index %0d, required 640 to bank %0d", v, wrAddrLog.size(), r, bank);
            end
        end
    endtask

    task automatic test_underrun();
        int r;
        clearLogs();
        checks++;
        if (out_underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL underrun_pre: got %b, required 0", out_underrun);
        end
        ackHold = 1'b1;
        pulseTrigger(4, 1'b0);
        pulseTrigger(5, 1'b1);
        checks++;
        if (out_underrun !== 1'b1 || out_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underrun_set: underrun=%b busy=%b, required 1 1", out_underrun, out_busy);
        end
        ackHold = 1'b0;
        waitIdle("underrun");
        r = reqMismatch(20'd3200);
        checks++;
        if (r != -1) begin
            errors++;
            $display("[TB] FAIL underrun_line5_reqs: %0d reqs, bad index %0d, required 20 at 3200+32*k", reqLog.size(), r);
        end
        r = writeMismatch(20'd3200, 1'b1);
        checks++;
        if (r != -1) begin
            errors++;
            $display("[TB] FAIL underrun_line5_writes: %0d writes, bad index %0d, required 640 to bank 1", wrAddrLog.size(), r);
        end
        checks++;
        if (out_underrun !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underrun_sticky: got %b, required 1", out_underrun);
        end
        clearLogs();
        pulseTrigger(6, 1'b0);
        waitIdle("line7");
        r = reqMismatch(20'd4480);
        checks++;
        if (r != -1) begin
            errors++;
            $display("[TB] FAIL line7_reqs: %0d reqs, bad index %0d, required 20 at 4480+32*k", reqLog.size(), r);
        end
        r = writeMismatch(20'd4480, 1'b1);
        checks++;
        if (r != -1) begin
            errors++;
            $display("[TB] FAIL line7_writes: %0d writes, bad index %0d, required 640 to bank 1", wrAddrLog.size(), r);
        end
        @(negedge pclk);
        clr_underrun = 1'b1;
        @(negedge pclk);
        clr_underrun = 1'b0;
        checks++;
        if (out_underrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL underrun_clear: got %b, required 0", out_underrun);
        end
    endtask

    task automatic test_blanking();
        clearLogs();
        for (int v = 479; v <= 523; v++) begin
            pulseTrigger(v, 1'b0);
            checks++;
            if (mem_req !== 1'b0 || out_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL blank_v%0d: req=%b busy=%b, required 0 0", v, mem_req, out_busy);
            end
        end
        spurious = 1'b1;
        repeat (10) @(negedge pclk);
        spurious = 1'b0;
        repeat (3) @(negedge pclk);
        checks++;
        if (wrAddrLog.size() != 0 || reqLog.size() != 0) begin
            errors++;
            $display("[TB] FAIL blank_activity: %0d writes %0d reqs, required 0 0", wrAddrLog.size(), reqLog.size());
        end
    endtask

    task automatic test_reset_mid_data();
        int r;
        int n = 0;
        clearLogs();
        pulseTrigger(524, 1'b0);
        while (wrAddrLog.size() < 10 && n < 200) begin
            @(negedge pclk);
            n++;
        end
        checks++;
        if (wrAddrLog.size() < 10) begin
            errors++;
            $display("[TB] FAIL midreset_reach: %0d writes seen, required 10", wrAddrLog.size());
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || lb_wr_en !== 1'b0 || out_busy !== 1'b0 || lb_wr_data !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: req=%b wr_en=%b busy=%b wr_data=%h, required 0 0 0 0", mem_req, lb_wr_en, out_busy, lb_wr_data);
        end
        repeat (3) @(negedge pclk);
        reset_n = 1'b1;
        repeat (2) @(negedge pclk);
        clearLogs();
        pulseTrigger(524, 1'b0);
        waitIdle("restart");
        r = reqMismatch(20'd0);
        checks++;
        if (r != -1) begin
            errors++;
            $display("[TB] FAIL restart_reqs: %0d reqs, bad index %0d, required 20 at 0+32*k", reqLog.size(), r);
        end
        r = writeMismatch(20'd0, 1'b0);
        checks++;
        if (r != -1) begin
            errors++;
            $display("[TB] FAIL restart_writes: %0d writes, bad index %0d, required 640 to bank 0", wrAddrLog.size(), r);
        end
    endtask

    initial begin : main
        test_reset();
        test_line0();
        test_line1();
        test_ack_stall();
        test_back_to_back();
        test_underrun();
        test_blanking();
        test_reset_mid_data();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
